input_fm_pingpong: RTL and testbench
====================================

// Module: input_fm_pingpong
// PURPOSE
//  Next-generation input feature-map tile buffer with X parametrised banks and two pages
//  (ping/pong), so the next tile can load while the compute array reads the current one.
//  Sits between the input-FM load FIFO (DDR side) and the convolution PEs.
//  Each channel slice (Tr*Tc words) is written to one bank: channel c -> bank c%X, slot c/X.
//  X independent synchronous read ports, one per bank.
// PARAMETERS
//  DW  32  data width
//  Tm  16  channels per tile
//  Tr  64  rows per tile
//  Tc  16  cols per tile
//  X   4   number of banks / read ports (>=1)
//  AW  16  per-bank local read address width; must satisfy 2^AW >= ceil(Tm/X)*Tr*Tc
// PORTS
//  clk               in   1     clock
//  rst               in   1     async reset, active-high
//  fifo_data         in   DW    load FIFO read data, valid the cycle after fifo_pop
//  fifo_empty        in   1     load FIFO empty
//  fifo_pop          out  1     load FIFO pop
//  load_start        in   1     pulse: begin loading one tile into the free page
//  load_ready        out  1     1 = IDLE and write page empty; load_start is accepted
//  load_done         out  1     1-cycle pulse: last word of tile written
//  rd_valid          out  1     1 = read page holds a complete tile
//  rd_release        in   1     pulse: compute finished with the read page
//  rd_addr           in   X*AW  packed local addresses, bank b = [b*AW +: AW]
//  rd_data           out  X*DW  packed read data, bank b = [b*DW +: DW]
// BEHAVIOUR
//  Constants: SLICE=Tr*Tc, TOTAL=Tm*SLICE, DEPTH=ceil(Tm/X)*SLICE per page per bank.
//  Storage: X banks of 2*DEPTH words; physical addr = page*DEPTH + local addr.
//  Reset: state=IDLE, wr_page=0, rd_page=0, full=2'b00, all counters 0; fifo_pop=0,
//   load_done=0, rd_valid=0, load_ready=1, rd_data=0. Reset mid-load abandons the tile;
//   already-popped words are lost, so upstream FIFO is reset with this block.
//  Load FSM: IDLE -> LOAD on load_start && load_ready; load_start otherwise ignored.
//   LOAD: fifo_pop = !fifo_empty && (pop_cnt < TOTAL). pop_cnt counts pops.
//   Write pipeline: word popped at cycle t is written at t+1 to bank (ch%X),
//   local addr (ch/X)*SLICE + off, where ch/off come from channel/offset counters that
//   advance on each write (off wraps at SLICE-1 -> 0 and ch increments).
//   LOAD -> DONE when pop_cnt reaches TOTAL; DONE lasts one cycle, after the final write.
//   In DONE: full[wr_page] <= 1, wr_page toggles, counters clear, load_done=1 -> IDLE.
//   Stall: fifo_empty mid-tile only pauses pops; no timeout.
//  Page handshake: rd_valid = full[rd_page]. rd_release while rd_valid clears
//   full[rd_page] and toggles rd_page. rd_release while !rd_valid is ignored.
//   If rd_release and DONE fall in the same cycle, both take effect (different pages).
//   load_ready = (state==IDLE) && !full[wr_page]. With both pages full, loads block
//   until release.
//  Reads: rd_data[b] registered, latency 1: addr at cycle t -> data at t+1, read from
//   rd_page. Reads are legal every cycle. Data is undefined when rd_valid=0 or local
//   addr >= DEPTH. Unwritten slots (Tm not multiple of X) return stale data.
// TESTING
//  (X=4,Tm=6,Tr=2,Tc=2; SLICE=4, TOTAL=24, DEPTH=8)
//  1 FIFO holds 0..23, load_start -> 24 pops in 24 cycles; load_done 1 cycle after last pop;
//    rd_valid=1; bank0 addr4 = 16, bank1 addr3 = 7, bank1 addr7 = 23.
//  2 Read bank2 addr0 at t -> rd_data[2*DW +: DW] = 8 at t+1; all 4 ports read in the
//    same cycle.
//  3 FIFO empty toggles every other cycle -> pops only when !empty; final contents same as 1.
//  4 Load tile A, then load tile B (100..123) with no release -> B goes to page 1;
//    load_ready=0 after B; reads still return A; rd_release -> rd_valid stays 1, reads
//    return B; load_ready=1.
//  5 rd_release in the same cycle as load_done of B -> page 0 freed, page 1 full,
//    rd_valid=1.
//  6 rst asserted after 10 pops -> fifo_pop=0, rd_valid=0, load_ready=1 immediately;
//    new load_start reloads page 0.

Source files
------------

// File: rtl/input_fm_pingpong.sv
// Ping-pong input feature-map tile buffer.
// X banks, two pages each. The load side streams one tile from the load FIFO
// into the free page. The compute side reads the other page through X
// independent registered read ports. Channel c lands in bank c%X, slot c/X.
module input_fm_pingpong #(
    parameter int DW = 32,
    parameter int Tm = 16,
    parameter int Tr = 64,
    parameter int Tc = 16,
    parameter int X  = 4,
    parameter int AW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DW-1:0]   fifo_data,
    input  logic            fifo_empty,
    output logic            fifo_pop,
    input  logic            load_start,
    output logic            load_ready,
    output logic            load_done,
    output logic            rd_valid,
    input  logic            rd_release,
    input  logic [X*AW-1:0] rd_addr,
    output logic [X*DW-1:0] rd_data
);

    localparam int SLICE = Tr * Tc;
    localparam int TOTAL = Tm * SLICE;
    localparam int SLOTS = (Tm + X - 1) / X;
    localparam int DEPTH = SLOTS * SLICE;
    localparam int MEMD  = 2 * DEPTH;
    localparam int PAW   = $clog2(MEMD);
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int BW    = (X > 1) ? $clog2(X) : 1;
    localparam int OW    = (SLICE > 1) ? $clog2(SLICE) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic          wr_page;
    logic          rd_page;
    logic [1:0]    full;
    logic [CW-1:0] pop_cnt;
    logic          last_pop;
    logic          vld_p1;
    logic [BW-1:0] bank_sel;
    logic [OW-1:0] off_cnt;
    logic [PAW-1:0] wr_ptr [X];

    assign fifo_pop   = (state == S_LOAD) && !fifo_empty && (pop_cnt < CW'(TOTAL));
    assign last_pop   = fifo_pop && (pop_cnt == CW'(TOTAL - 1));
    assign load_ready = (state == S_IDLE) && !full[wr_page];
    assign load_done  = (state == S_DONE);
    assign rd_valid   = full[rd_page];

    // Load FSM: DONE follows the cycle of the final pop, coinciding with the final write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (load_start && load_ready) state <= S_LOAD;
                S_LOAD:  if (last_pop) state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Pop counter and the one-cycle write-valid that tracks FIFO read latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pop_cnt <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= fifo_pop;
            if (state == S_DONE)
                pop_cnt <= '0;
            else if (fifo_pop)
                pop_cnt <= pop_cnt + CW'(1);
        end
    end

    // Write placement: offset within slice, bank rotation per slice, and a
    // per-bank pointer (slices of one bank are contiguous, so it just counts up)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_sel <= '0;
            off_cnt  <= '0;
            for (int i = 0; i < X; i++) wr_ptr[i] <= '0;
        end else begin
            if (vld_p1) begin
                for (int i = 0; i < X; i++)
                    if (bank_sel == BW'(i)) wr_ptr[i] <= wr_ptr[i] + PAW'(1);
                if (off_cnt == OW'(SLICE - 1)) begin
                    off_cnt  <= '0;
                    bank_sel <= (bank_sel == BW'(X - 1)) ? '0 : bank_sel + BW'(1);
                end else begin
                    off_cnt <= off_cnt + OW'(1);
                end
            end
            if (state == S_DONE) begin
                bank_sel <= '0;
                off_cnt  <= '0;
                for (int i = 0; i < X; i++) wr_ptr[i] <= '0;
            end
        end
    end

    // Page bookkeeping: DONE and release always target different pages
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_page <= 1'b0;
            rd_page <= 1'b0;
            full    <= 2'b00;
        end else begin
            if (state == S_DONE) begin
                full[wr_page] <= 1'b1;
                wr_page       <= ~wr_page;
            end
            if (rd_release && full[rd_page]) begin
                full[rd_page] <= 1'b0;
                rd_page       <= ~rd_page;
            end
        end
    end

    for (genvar b = 0; b < X; b++) begin : g_bank
        logic [DW-1:0]  mem [MEMD];
        logic [DW-1:0]  rdq;
        logic           we;
        logic [PAW-1:0] waddr;
        logic [AW+1:0]  rsum;

        assign we    = vld_p1 && (bank_sel == BW'(b));
        assign waddr = wr_page ? PAW'(DEPTH) + wr_ptr[b] : wr_ptr[b];
        assign rsum  = (rd_page ? (AW+2)'(DEPTH) : '0) + {2'b00, rd_addr[b*AW +: AW]};
        assign rd_data[b*DW +: DW] = rdq;

        // Bank storage write port (data, not reset)
        always_ff @(posedge clk) begin
            if (we) mem[waddr] <= fifo_data;
        end

        // Registered read port; addresses past the bank return zero
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                rdq <= '0;
            else
                rdq <= (rsum < (AW+2)'(MEMD)) ? mem[rsum[PAW-1:0]] : '0;
        end
    end

endmodule

// File: tb/tb_input_fm_pingpong.sv
// Directed bench for input_fm_pingpong with a small 6-channel 2x2 tile over 4 banks.
module tb_input_fm_pingpong;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int X  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   fifo_data = '0;
    logic            fifo_empty;
    logic            fifo_pop;
    logic            load_start;
    logic            load_ready;
    logic            load_done;
    logic            rd_valid;
    logic            rd_release;
    logic [X*AW-1:0] rd_addr;
    logic [X*DW-1:0] rd_data;

    input_fm_pingpong #(.DW(DW), .Tm(6), .Tr(2), .Tc(2), .X(X), .AW(AW)) dut (
        .clk(clk), .rst(rst), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
        .fifo_pop(fifo_pop), .load_start(load_start), .load_ready(load_ready),
        .load_done(load_done), .rd_valid(rd_valid), .rd_release(rd_release),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    // Load FIFO model
    logic [31:0] fmem [256];
    int  ri = 0;
    int  wi = 0;
    bit  stall_en = 0;
    bit  tog = 0;
    bit  bad_pop = 0;
    int  cyc = 0;
    int  pops = 0;
    int  last_pop = 0;
    int  pop_base = 0;
    int  s_cyc = 0;
    int  checks = 0;
    int  errors = 0;

    assign fifo_empty = (ri == wi) || (stall_en && tog);

    always @(posedge clk or posedge rst) begin
        if (rst) ri <= wi;
        else if (fifo_pop) begin
            fifo_data <= fmem[ri % 256];
            ri <= ri + 1;
        end
    end

    always @(posedge clk) begin
        tog <= ~tog;
        cyc <= cyc + 1;
        if (fifo_pop) begin
            pops <= pops + 1;
            last_pop <= cyc;
            if (fifo_empty) bad_pop <= 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input int base);
        for (int k = 0; k < 24; k++) begin
            fmem[wi % 256] = 32'(base + k);
            wi++;
        end
    endtask

    task automatic start_load();
        pop_base = pops;
        s_cyc = cyc;
        load_start = 1;
        @(negedge clk);
        load_start = 0;
    endtask

    task automatic wait_done(input bit rel, output int lat, output int np);
        bit seen;
        seen = 0;
        lat = -1;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (load_done) begin
                seen = 1;
                lat = cyc - last_pop;
                if (rel) rd_release = 1;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        np = pops - pop_base;
        @(negedge clk);
        rd_release = 0;
        chk("done_pulse", 32'(load_done), 32'd0);
    endtask

    task automatic rd1(input string tag, input int b, input int a, input int exp);
        rd_addr[b*AW +: AW] = AW'(a);
        @(negedge clk);
        chk(tag, rd_data[b*DW +: DW], 32'(exp));
    endtask

    task automatic release_page();
        rd_release = 1;
        @(negedge clk);
        rd_release = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, np, p;
        rst = 1; load_start = 0; rd_release = 0; rd_addr = '0;
        repeat (3) @(negedge clk);
        chk("rst_fifo_pop", 32'(fifo_pop), 0);
        chk("rst_load_ready", 32'(load_ready), 1);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_load_done", 32'(load_done), 0);
        chk("rst_rd_data0", rd_data[31:0], 0);
        rst = 0;
        @(negedge clk);
        // release with nothing valid must not move the read page
        release_page();

        // 1: straight load of 0..23 into page 0
        fill(0);
        start_load();
        wait_done(0, lat, np);
        chk("t1_pops", 32'(np), 24);
        chk("t1_span", 32'(last_pop - s_cyc), 24);
        chk("t1_done_lat", 32'(lat), 1);
        chk("t1_rd_valid", 32'(rd_valid), 1);
        chk("t1_load_ready", 32'(load_ready), 1);
        rd1("t1_b0a4", 0, 4, 16);
        rd1("t1_b1a3", 1, 3, 7);
        rd1("t1_b1a7", 1, 7, 23);

        // 2: all four ports in one cycle
        rd_addr = {16'd2, 16'd0, 16'd1, 16'd0};
        @(negedge clk);
        chk("t2_b0", rd_data[0*DW +: DW], 0);
        chk("t2_b1", rd_data[1*DW +: DW], 5);
        chk("t2_b2", rd_data[2*DW +: DW], 8);
        chk("t2_b3", rd_data[3*DW +: DW], 14);
        release_page();
        chk("t2_rel_valid", 32'(rd_valid), 0);

        // 3: stalling FIFO, tile goes to page 1
        stall_en = 1;
        fill(0);
        start_load();
        wait_done(0, lat, np);
        stall_en = 0;
        chk("t3_pops", 32'(np), 24);
        chk("t3_done_lat", 32'(lat), 1);
        chk("t3_no_empty_pop", 32'(bad_pop), 0);
        chk("t3_rd_valid", 32'(rd_valid), 1);
        rd1("t3_b0a4", 0, 4, 16);
        rd1("t3_b1a7", 1, 7, 23);
        rd1("t3_b2a0", 2, 0, 8);
        release_page();

        // 4: tile A then tile B without release
        fill(50);
        start_load();
        wait_done(0, lat, np);
        chk("t4_a_valid", 32'(rd_valid), 1);
        chk("t4_a_ready", 32'(load_ready), 1);
        fill(100);
        start_load();
        wait_done(0, lat, np);
        chk("t4_b_ready", 32'(load_ready), 0);
        chk("t4_b_valid", 32'(rd_valid), 1);
        rd1("t4_reads_a", 0, 4, 66);
        fill(150);
        p = pops;
        load_start = 1;
        @(negedge clk);
        load_start = 0;
        repeat (4) @(negedge clk);
        chk("t4_blocked_pops", 32'(pops - p), 0);
        release_page();
        chk("t4_rel_valid", 32'(rd_valid), 1);
        chk("t4_rel_ready", 32'(load_ready), 1);
        rd1("t4_reads_b0", 0, 4, 116);
        rd1("t4_reads_b1", 1, 7, 123);

        // 5: release lands in the DONE cycle of tile C
        start_load();
        wait_done(1, lat, np);
        chk("t5_valid", 32'(rd_valid), 1);
        chk("t5_ready", 32'(load_ready), 1);
        rd1("t5_b1a7", 1, 7, 173);
        rd1("t5_b0a4", 0, 4, 166);

        // 6: reset mid-load, then reload page 0
        fill(0);
        start_load();
        for (int i = 0; i < 100 && (pops - pop_base) < 10; i++) @(negedge clk);
        chk("t6_ten_pops", 32'(pops - pop_base), 10);
        rst = 1;
        #1;
        chk("t6_rst_pop", 32'(fifo_pop), 0);
        chk("t6_rst_valid", 32'(rd_valid), 0);
        chk("t6_rst_ready", 32'(load_ready), 1);
        chk("t6_rst_rd_data", rd_data[31:0], 0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        fill(0);
        start_load();
        wait_done(0, lat, np);
        chk("t6_pops", 32'(np), 24);
        chk("t6_valid", 32'(rd_valid), 1);
        rd1("t6_b0a4", 0, 4, 16);
        rd1("t6_b1a3", 1, 3, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
